// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop RxD synchroniser, 16x-oversampled start/data/parity/stop
// framing, and a one-clk Rx_VALID strobe that publishes the byte with its error flags.
module uart_receiver #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx_EN,
    input  logic                 sample_ENABLE,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR,
    output logic                 Rx_VALID
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
    localparam logic       ODD      = (PARITY_ODD != 0);

    logic [1:0]           sync_q;
    logic                 rx;
    state_t               state_q, state_d;
    logic                 armed_q, armed_d;
    logic [3:0]           tick_q, tick_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_q, ferr_d;
    logic                 valid_q, valid_d;

    assign rx = sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], RxD};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        data_d     = data_q;
        perr_out_d = perr_out_q;
        ferr_d     = ferr_q;
        valid_d    = 1'b0;

        if (!Rx_EN) begin
            state_d = S_IDLE;
            armed_d = 1'b0;
            tick_d  = '0;
            bit_d   = '0;
        end else if (sample_ENABLE) begin
            // Counter free-runs mod 16; each sample point is where it wraps from 15.
            tick_d = tick_q + 4'd1;
            unique case (state_q)
                S_IDLE: begin
                    tick_d = '0;
                    if (rx) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (tick_q == 4'd7) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick_q == 4'd15) begin
                        shift_d = {rx, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == BIT_LAST) begin
                            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick_q == 4'd15) begin
                        perr_d  = ((^shift_q) ^ rx) != ODD;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick_q == 4'd15) begin
                        // A low stop bit disarms so a held-low break cannot retrigger.
                        armed_d    = rx;
                        state_d    = S_IDLE;
                        tick_d     = '0;
                        bit_d      = '0;
                        valid_d    = 1'b1;
                        data_d     = shift_q;
                        perr_out_d = (PARITY_EN != 0) ? perr_q : 1'b0;
                        ferr_d     = ~rx;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_PERROR = perr_out_q;
    assign Rx_FERROR = ferr_q;
    assign Rx_VALID  = valid_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver (8E1): vector table, hand-written corner sequences and
// randomized frames checked against a bit-level frame model.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       Rx_EN;
    logic       sample_ENABLE;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_VALID;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_per = 27;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rx_t;

    typedef struct {
        logic [7:0] d;
        logic       pb;
        logic       st;
        logic [7:0] ed;
        logic       epe;
        logic       efe;
    } vec_t;

    rx_t  got_q[$];
    logic prev_v = 1'b0;

    uart_receiver #(
        .DATA_BITS (8),
        .PARITY_EN (1),
        .PARITY_ODD(0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Rx_EN        (Rx_EN),
        .sample_ENABLE(sample_ENABLE),
        .RxD          (RxD),
        .Rx_DATA      (Rx_DATA),
        .Rx_PERROR    (Rx_PERROR),
        .Rx_FERROR    (Rx_FERROR),
        .Rx_VALID     (Rx_VALID)
    );

    always #10 clk = ~clk;

    initial begin
        int sc;
        sc = 0;
        sample_ENABLE = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sc >= tick_per - 1) begin
                sample_ENABLE = 1'b1;
                sc = 0;
            end else begin
                sample_ENABLE = 1'b0;
                sc++;
            end
        end
    end

    always @(negedge clk) begin
        if (Rx_VALID === 1'b1) begin
            n_checks++;
            if (prev_v) begin
                n_fail++;
                $display("FAIL valid_width: Rx_VALID high on consecutive clks, required single-clk pulse");
            end
            got_q.push_back({Rx_DATA, Rx_PERROR, Rx_FERROR});
        end
        prev_v = (Rx_VALID === 1'b1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * 16 * tick_per) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        RxD = v;
        wait_bits(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic st);
        drive_bit(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 1);
        drive_bit(pb, 1);
        drive_bit(st, 1);
    endtask

    task automatic expect_one(input string nm, input logic [7:0] d, input logic pe, input logic fe);
        rx_t r;
        chk({nm, " pulses"}, got_q.size(), 1);
        if (got_q.size() > 0) begin
            r = got_q.pop_front();
            chk({nm, " data"}, r.d, d);
            chk({nm, " perr"}, r.pe, pe);
            chk({nm, " ferr"}, r.fe, fe);
        end
        got_q.delete();
    endtask

    initial begin
        vec_t       tbl[4];
        rx_t        r;
        logic [7:0] d;
        logic       pb;
        logic       st;
        int         gap;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};

        reset = 1'b1;
        Rx_EN = 1'b1;
        RxD   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset data", Rx_DATA, 8'h00);
        chk("reset perr", Rx_PERROR, 1'b0);
        chk("reset ferr", Rx_FERROR, 1'b0);
        chk("reset valid", Rx_VALID, 1'b0);
        reset = 1'b0;
        drive_bit(1'b1, 2);

        // Vector table at the nominal 27-clk strobe period.
        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].d, tbl[i].pb, tbl[i].st);
            drive_bit(1'b1, 2);
            expect_one($sformatf("vec%0d", i), tbl[i].ed, tbl[i].epe, tbl[i].efe);
        end

        // Hand-written sequences use a shorter strobe period to keep runtime small.
        tick_per = 8;
        drive_bit(1'b1, 2);

        send_frame(8'h55, 1'b0, 1'b0);
        drive_bit(1'b0, 40);
        expect_one("break", 8'h55, 1'b0, 1'b1);
        drive_bit(1'b1, 2);
        send_frame(8'h0F, 1'b0, 1'b1);
        drive_bit(1'b1, 2);
        expect_one("after_break", 8'h0F, 1'b0, 1'b0);

        RxD = 1'b0;
        repeat (4 * tick_per) @(posedge clk);
        #1;
        drive_bit(1'b1, 2);
        chk("glitch pulses", got_q.size(), 0);
        send_frame(8'hFF, 1'b0, 1'b1);
        drive_bit(1'b1, 2);
        expect_one("after_glitch", 8'hFF, 1'b0, 1'b0);

        drive_bit(1'b0, 1);
        drive_bit(1'b1, 1);
        drive_bit(1'b0, 1);
        drive_bit(1'b0, 1);
        reset = 1'b1;
        RxD   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset data", Rx_DATA, 8'h00);
        chk("midreset perr", Rx_PERROR, 1'b0);
        chk("midreset ferr", Rx_FERROR, 1'b0);
        chk("midreset valid", Rx_VALID, 1'b0);
        drive_bit(1'b1, 2);
        send_frame(8'h81, 1'b0, 1'b1);
        drive_bit(1'b1, 2);
        expect_one("after_reset", 8'h81, 1'b0, 1'b0);

        drive_bit(1'b0, 1);
        drive_bit(1'b1, 1);
        drive_bit(1'b0, 1);
        Rx_EN = 1'b0;
        drive_bit(1'b0, 1);
        drive_bit(1'b1, 10);
        chk("abort pulses", got_q.size(), 0);
        chk("abort hold data", Rx_DATA, 8'h81);
        Rx_EN = 1'b1;
        drive_bit(1'b1, 1);
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1);
        drive_bit(1'b1, 2);
        chk("b2b pulses", got_q.size(), 2);
        if (got_q.size() == 2) begin
            r = got_q.pop_front();
            chk("b2b0 data", r.d, 8'h01);
            chk("b2b0 errs", {r.pe, r.fe}, 2'b00);
            r = got_q.pop_front();
            chk("b2b1 data", r.d, 8'h80);
            chk("b2b1 errs", {r.pe, r.fe}, 2'b00);
        end
        got_q.delete();

        // Randomized frames against a frame-level model: parity error iff the count
        // of ones over data+parity is odd, framing error iff the stop bit is low.
        tick_per = 3;
        drive_bit(1'b1, 2);
        for (int k = 0; k < 24; k++) begin
            d  = 8'($urandom);
            pb = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 4) != 0);
            send_frame(d, pb, st);
            expect_one($sformatf("rand%0d", k), d, ($countones({d, pb}) % 2) != 0, !st);
            gap = st ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            if (gap > 0) drive_bit(1'b1, gap);
        end
        drive_bit(1'b1, 2);
        chk("final stray pulses", got_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
